// File: rtl/kiwi_weight_streamer.sv
// Streams a self-describing weight image from flash into on-chip weight storage,
// verifying header magic, segment count, segment lengths and per-segment checksums.
module kiwi_weight_streamer #(
  parameter int ADDR_WIDTH     = 24,
  parameter int MAX_SEGS       = 4,
  parameter int MAX_SEG_WORDS  = 1024,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int SEG_W = (MAX_SEGS > 1) ? $clog2(MAX_SEGS) : 1,
  localparam int IDX_W = (MAX_SEG_WORDS > 1) ? $clog2(MAX_SEG_WORDS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  output logic                  mem_valid_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_ready_i,
  input  logic [31:0]           mem_rdata_i,
  output logic                  wr_en_o,
  output logic [SEG_W-1:0]      wr_seg_o,
  output logic [IDX_W-1:0]      wr_index_o,
  output logic [31:0]           wr_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  weights_valid_o,
  output logic                  error_o,
  output logic [2:0]            err_code_o
);

  localparam int          LEN_W = $clog2(MAX_SEG_WORDS + 1);
  localparam int          TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [15:0] MAGIC = 16'h4B57;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_SEG_LEN, S_SEG_DATA, S_SEG_CSUM, S_DONE, S_ERROR
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  mem_valid_q;
  logic [TMO_W-1:0]      tmo_q;
  logic [31:0]           sum_q;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      word_q;
  logic [7:0]            seg_cnt_q;
  logic [7:0]            seg_q;
  logic                  wr_en_q;
  logic [SEG_W-1:0]      wr_seg_q;
  logic [IDX_W-1:0]      wr_index_q;
  logic [31:0]           wr_data_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  weights_valid_q;
  logic                  error_q;
  logic [2:0]            err_code_q;

  logic [2:0]            fail_d;
  logic                  last_word_d;
  logic                  last_seg_d;
  logic                  unused_base_lsbs;

  assign unused_base_lsbs = ^base_addr_i[1:0];

  // Verdict on the word arriving this cycle; only consumed at a handshake.
  always_comb begin
    fail_d      = 3'd0;
    last_word_d = ((word_q + LEN_W'(1)) == len_q);
    last_seg_d  = ((seg_q + 8'd1) == seg_cnt_q);
    case (state_q)
      S_HDR: begin
        if (mem_rdata_i[31:16] != MAGIC) begin
          fail_d = 3'd1;
        end else if ((mem_rdata_i[7:0] == 8'd0) || (mem_rdata_i[7:0] > 8'(MAX_SEGS))) begin
          fail_d = 3'd2;
        end else begin
          fail_d = 3'd0;
        end
      end
      S_SEG_LEN: begin
        if ((mem_rdata_i == 32'd0) || (mem_rdata_i > 32'(MAX_SEG_WORDS))) begin
          fail_d = 3'd3;
        end else begin
          fail_d = 3'd0;
        end
      end
      S_SEG_CSUM: begin
        if (mem_rdata_i != sum_q) begin
          fail_d = 3'd4;
        end else begin
          fail_d = 3'd0;
        end
      end
      default: fail_d = 3'd0;
    endcase
  end

  // Load sequencer: one request per word, a one-cycle gap after every handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      mem_valid_q     <= 1'b0;
      tmo_q           <= '0;
      sum_q           <= 32'd0;
      len_q           <= '0;
      word_q          <= '0;
      seg_cnt_q       <= 8'd0;
      seg_q           <= 8'd0;
      wr_en_q         <= 1'b0;
      wr_seg_q        <= '0;
      wr_index_q      <= '0;
      wr_data_q       <= 32'd0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      weights_valid_q <= 1'b0;
      error_q         <= 1'b0;
      err_code_q      <= 3'd0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start_i) begin
            state_q         <= S_HDR;
            addr_q          <= {base_addr_i[ADDR_WIDTH-1:2], 2'b00};
            tmo_q           <= '0;
            busy_q          <= 1'b1;
            error_q         <= 1'b0;
            err_code_q      <= 3'd0;
            weights_valid_q <= 1'b0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_HDR, S_SEG_LEN, S_SEG_DATA, S_SEG_CSUM: begin
          if (!mem_valid_q) begin
            mem_valid_q <= 1'b1;
          end else if (mem_ready_i) begin
            mem_valid_q <= 1'b0;
            addr_q      <= addr_q + ADDR_WIDTH'(4);
            tmo_q       <= '0;
            if (fail_d != 3'd0) begin
              state_q    <= S_ERROR;
              error_q    <= 1'b1;
              err_code_q <= fail_d;
              busy_q     <= 1'b0;
            end else begin
              case (state_q)
                S_HDR: begin
                  seg_cnt_q <= mem_rdata_i[7:0];
                  seg_q     <= 8'd0;
                  state_q   <= S_SEG_LEN;
                end
                S_SEG_LEN: begin
                  len_q   <= mem_rdata_i[LEN_W-1:0];
                  sum_q   <= mem_rdata_i;
                  word_q  <= '0;
                  state_q <= S_SEG_DATA;
                end
                S_SEG_DATA: begin
                  sum_q      <= sum_q + mem_rdata_i;
                  wr_en_q    <= 1'b1;
                  wr_seg_q   <= seg_q[SEG_W-1:0];
                  wr_index_q <= word_q[IDX_W-1:0];
                  wr_data_q  <= mem_rdata_i;
                  word_q     <= word_q + LEN_W'(1);
                  if (last_word_d) begin
                    state_q <= S_SEG_CSUM;
                  end else begin
                    state_q <= S_SEG_DATA;
                  end
                end
                S_SEG_CSUM: begin
                  if (last_seg_d) begin
                    state_q         <= S_DONE;
                    done_q          <= 1'b1;
                    weights_valid_q <= 1'b1;
                    busy_q          <= 1'b0;
                  end else begin
                    seg_q   <= seg_q + 8'd1;
                    state_q <= S_SEG_LEN;
                  end
                end
                default: state_q <= S_IDLE;
              endcase
            end
          end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES)) begin
            mem_valid_q <= 1'b0;
            state_q     <= S_ERROR;
            error_q     <= 1'b1;
            err_code_q  <= 3'd5;
            busy_q      <= 1'b0;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_valid_o     = mem_valid_q;
  assign mem_addr_o      = addr_q;
  assign wr_en_o         = wr_en_q;
  assign wr_seg_o        = wr_seg_q;
  assign wr_index_o      = wr_index_q;
  assign wr_data_o       = wr_data_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign weights_valid_o = weights_valid_q;
  assign error_o         = error_q;
  assign err_code_o      = err_code_q;

endmodule

// File: tb/tb_kiwi_weight_streamer.sv
// Randomised bench for kiwi_weight_streamer: a flash responder plus an image-level
// reference model that predicts every output cycle by cycle.
module tb_kiwi_weight_streamer;
  localparam int TMO  = 4096;
  localparam int MAXW = 1024;

  logic        clk_i = 1'b0;
  logic        rst_ni, start_i, mem_ready_i;
  logic [23:0] base_addr_i;
  logic [31:0] mem_rdata_i;
  logic        mem_valid_o, wr_en_o, busy_o, done_o, weights_valid_o, error_o;
  logic [23:0] mem_addr_o;
  logic [1:0]  wr_seg_o;
  logic [9:0]  wr_index_o;
  logic [31:0] wr_data_o;
  logic [2:0]  err_code_o;

  int checks = 0, errors = 0;

  always #5 clk_i = ~clk_i;

  kiwi_weight_streamer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .base_addr_i(base_addr_i),
    .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o), .mem_ready_i(mem_ready_i),
    .mem_rdata_i(mem_rdata_i), .wr_en_o(wr_en_o), .wr_seg_o(wr_seg_o),
    .wr_index_o(wr_index_o), .wr_data_o(wr_data_o), .busy_o(busy_o), .done_o(done_o),
    .weights_valid_o(weights_valid_o), .error_o(error_o), .err_code_o(err_code_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // flash image and its parsed meaning: kind 0 hdr,1 len,2 data,3 csum,4 unread
  logic [31:0] flash [int];
  logic [31:0] img [$];
  int kind_a [64], seg_a [64], idx_a [64], term_a [64];
  int ana_code, ana_writes;

  function automatic logic [31:0] img_word(input int k);
    if (k < img.size()) return img[k];
    return 32'hDEADBEEF;
  endfunction

  function automatic logic [31:0] flash_rd(input logic [23:0] a);
    if (flash.exists(int'(a))) return flash[int'(a)];
    return 32'hDEADBEEF;
  endfunction

  task automatic analyze();
    logic [31:0] w, sum, len;
    int k, segs;
    for (int i = 0; i < 64; i++) begin
      kind_a[i] = 4; term_a[i] = -1; seg_a[i] = 0; idx_a[i] = 0;
    end
    ana_writes = 0; ana_code = -1;
    w = img_word(0); kind_a[0] = 0;
    if (w[31:16] != 16'h4B57) begin term_a[0] = 1; ana_code = 1; return; end
    if (w[7:0] == 8'd0 || w[7:0] > 8'd4) begin term_a[0] = 2; ana_code = 2; return; end
    segs = int'(w[7:0]);
    k = 1;
    for (int s = 0; s < segs; s++) begin
      len = img_word(k); kind_a[k] = 1;
      if (len == 32'd0 || len > 32'(MAXW)) begin term_a[k] = 3; ana_code = 3; return; end
      sum = len; k++;
      for (int i = 0; i < int'(len); i++) begin
        if (k >= 63) begin ana_code = -2; return; end
        kind_a[k] = 2; seg_a[k] = s; idx_a[k] = i;
        sum = sum + img_word(k); ana_writes++; k++;
      end
      kind_a[k] = 3;
      if (img_word(k) != sum) begin term_a[k] = 4; ana_code = 4; return; end
      if (s == segs - 1) begin term_a[k] = 0; ana_code = 0; end
      k++;
    end
  endtask

  // model state (next-cycle expectations) and per-load statistics
  bit          active;
  int          k_cur, wcnt;
  logic [23:0] base_al;
  logic        exp_mv, exp_busy, exp_done, exp_err, exp_wv, exp_wr;
  logic [2:0]  exp_code;
  logic [1:0]  exp_seg;
  logic [9:0]  exp_idx;
  logic [31:0] exp_data;
  int          wr_count, done_seen, hs_count;
  logic [23:0] first_addr, prev_hs_addr;
  bit          first_seen, saw_wrap;
  int          wait_mode = 0, force_wait = -1, wl;
  bit          req_open;

  task automatic model_finish(input int c);
    active = 1'b0; exp_busy = 1'b0;
    if (c == 0) begin exp_done = 1'b1; exp_wv = 1'b1; end
    else begin exp_err = 1'b1; exp_code = 3'(c); end
  endtask

  // compare, flash responder and model step, once per cycle on the falling edge
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        chk("rst_mem_valid", mem_valid_o, 0); chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_wr_en", wr_en_o, 0); chk("rst_wr_seg", wr_seg_o, 0);
        chk("rst_wr_index", wr_index_o, 0); chk("rst_wr_data", wr_data_o, 0);
        chk("rst_busy", busy_o, 0); chk("rst_done", done_o, 0);
        chk("rst_wv", weights_valid_o, 0); chk("rst_error", error_o, 0);
        chk("rst_err_code", err_code_o, 0);
        active = 1'b0; exp_mv = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
        exp_wv = 1'b0; exp_wr = 1'b0; exp_code = 3'd0; wcnt = 0; k_cur = 0;
        mem_ready_i = 1'b0; req_open = 1'b0;
      end else begin
        logic [23:0] ea;
        int kk;
        ea = base_al + 24'(4 * k_cur);
        chk("mem_valid", mem_valid_o, exp_mv);
        if (exp_mv) chk("mem_addr", mem_addr_o, ea);
        chk("busy", busy_o, exp_busy); chk("done", done_o, exp_done);
        chk("error", error_o, exp_err); chk("err_code", err_code_o, exp_code);
        chk("weights_valid", weights_valid_o, exp_wv); chk("wr_en", wr_en_o, exp_wr);
        if (exp_wr) begin
          chk("wr_seg", wr_seg_o, exp_seg); chk("wr_index", wr_index_o, exp_idx);
          chk("wr_data", wr_data_o, exp_data);
        end
        if (wr_en_o) wr_count++;
        if (done_o) done_seen++;
        if (mem_valid_o) begin
          if (!req_open) begin
            req_open = 1'b1;
            if (force_wait >= 0) begin wl = force_wait; force_wait = -1; end
            else wl = (wait_mode != 0) ? int'($urandom_range(0, 3)) : 0;
          end
          if (wl == 0) begin
            mem_ready_i = 1'b1; mem_rdata_i = flash_rd(mem_addr_o); req_open = 1'b0;
          end else begin
            mem_ready_i = 1'b0; mem_rdata_i = $urandom; wl--;
          end
        end else begin
          req_open = 1'b0;
          mem_ready_i = (wait_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
          mem_rdata_i = $urandom;
        end
        if (mem_valid_o && mem_ready_i) begin
          hs_count++;
          if (!first_seen) begin first_addr = mem_addr_o; first_seen = 1'b1; end
          if (prev_hs_addr == 24'hFFFFFC && mem_addr_o == 24'h000000) saw_wrap = 1'b1;
          prev_hs_addr = mem_addr_o;
        end
        exp_done = 1'b0; exp_wr = 1'b0;
        if (active) begin
          if (!exp_mv) begin
            exp_mv = 1'b1;
          end else if (mem_ready_i) begin
            kk = (k_cur > 63) ? 63 : k_cur;
            exp_mv = 1'b0; wcnt = 0; k_cur++;
            if (kind_a[kk] == 2) begin
              exp_wr = 1'b1; exp_seg = 2'(seg_a[kk]); exp_idx = 10'(idx_a[kk]);
              exp_data = img_word(kk);
            end
            if (term_a[kk] != -1) model_finish(term_a[kk]);
          end else if (wcnt == TMO) begin
            exp_mv = 1'b0; model_finish(5);
          end else begin
            wcnt++;
          end
        end else if (start_i) begin
          active = 1'b1; k_cur = 0; wcnt = 0;
          base_al = {base_addr_i[23:2], 2'b00};
          analyze();
          exp_busy = 1'b1; exp_err = 1'b0; exp_code = 3'd0; exp_wv = 1'b0; exp_mv = 1'b0;
        end
      end
    end
  end

  task automatic load_flash(input logic [23:0] base);
    logic [23:0] a;
    flash.delete();
    for (int k = 0; k < img.size(); k++) begin
      a = {base[23:2], 2'b00} + 24'(4 * k);
      flash[int'(a)] = img[k];
    end
  endtask

  task automatic begin_load(input logic [23:0] base, input int wm);
    wait_mode = wm;
    load_flash(base);
    wr_count = 0; done_seen = 0; hs_count = 0; first_seen = 1'b0;
    saw_wrap = 1'b0; prev_hs_addr = 24'h0;
    @(posedge clk_i); #1;
    base_addr_i = base; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input bit pulse);
    int n = 0;
    while (active && n < 20000) begin
      @(posedge clk_i); #1;
      n++;
      start_i = pulse && busy_o && ($urandom_range(0, 3) == 0);
      if (start_i) base_addr_i = $urandom;
    end
    start_i = 1'b0;
    if (active) begin
      checks++; errors++;
      $display("FAIL load_bound actual=busy required=idle within 20000 cycles");
    end
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  task automatic run_load(input logic [23:0] base, input int wm, input bit pulse);
    begin_load(base, wm);
    wait_idle(pulse);
  endtask

  task automatic set_plan();
    img = '{32'h4B570002, 32'd2, 32'h11, 32'h22, 32'h35, 32'd1, 32'hFFFFFFFF, 32'h0};
  endtask

  task automatic build_rand();
    int ns, corr, bad_s, len;
    logic [31:0] h, sum, d;
    ns = $urandom_range(1, 4); corr = $urandom_range(0, 4); bad_s = $urandom_range(0, ns - 1);
    h = {16'h4B57, 8'($urandom), 8'(ns)};
    if (corr == 1) h[31:16] = 16'($urandom_range(0, 16'h4B56));
    if (corr == 2) h[7:0] = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(5, 255));
    img.delete();
    img.push_back(h);
    for (int s = 0; s < ns; s++) begin
      len = $urandom_range(1, 6);
      if (corr == 3 && s == bad_s) len = ($urandom_range(0, 1) == 0) ? 0 : MAXW + 1;
      img.push_back(32'(len));
      if (len == 0 || len > MAXW) begin
        img.push_back($urandom);
        break;
      end
      sum = 32'(len);
      for (int i = 0; i < len; i++) begin
        d = $urandom; img.push_back(d); sum = sum + d;
      end
      if (corr == 4 && s == bad_s) sum = sum + 32'd1;
      img.push_back(sum);
    end
  endtask

  initial begin
    logic [31:0] csum;
    int n;
    rst_ni = 1'b0; start_i = 1'b0; base_addr_i = 24'h0; mem_ready_i = 1'b0; mem_rdata_i = 32'h0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_busy", busy_o, 0); chk("reset_mem_valid", mem_valid_o, 0);
    rst_ni = 1'b1;

    set_plan();
    run_load(24'h000103, 0, 1'b0);
    chk("plan_writes", wr_count, 3); chk("plan_done_seen", done_seen, 1);
    chk("plan_wv", weights_valid_o, 1); chk("plan_code", err_code_o, 0);
    chk("plan_first_addr", first_addr, 24'h000100);
    chk("model_plan_writes", ana_writes, 3); chk("model_plan_code", ana_code, 0);

    img = '{32'h12340001, 32'd1, 32'd5, 32'd6};
    run_load(24'h000200, 1, 1'b0);
    chk("magic_code", err_code_o, 1); chk("magic_error", error_o, 1);
    chk("magic_writes", wr_count, 0); chk("model_magic_code", ana_code, 1);
    img = '{32'h4B570000, 32'd1, 32'd5, 32'd6};
    run_load(24'h000200, 0, 1'b0);
    chk("count0_code", err_code_o, 2);
    img = '{32'h4B570005, 32'd1, 32'd5, 32'd6};
    run_load(24'h000200, 0, 1'b0);
    chk("count5_code", err_code_o, 2); chk("model_count5_code", ana_code, 2);

    img = '{32'h4B570001, 32'd0, 32'd7, 32'd7};
    run_load(24'h000300, 0, 1'b0);
    chk("len0_code", err_code_o, 3); chk("len0_reads", hs_count, 2);
    img = '{32'h4B570001, 32'd1025, 32'd7, 32'd7};
    run_load(24'h000300, 1, 1'b0);
    chk("len1025_code", err_code_o, 3); chk("len1025_reads", hs_count, 2);

    set_plan(); img[7] = 32'h00000001;
    run_load(24'h000100, 0, 1'b0);
    chk("csum_writes", wr_count, 3); chk("csum_code", err_code_o, 4);
    chk("csum_wv", weights_valid_o, 0); chk("model_csum_code", ana_code, 4);
    set_plan();
    run_load(24'h000100, 1, 1'b0);
    chk("restart_error", error_o, 0); chk("restart_wv", weights_valid_o, 1);

    force_wait = 5000;
    run_load(24'h000100, 0, 1'b0);
    chk("tmo_code", err_code_o, 5); chk("tmo_mem_valid", mem_valid_o, 0);
    chk("tmo_writes", wr_count, 0);
    force_wait = TMO;
    run_load(24'h000100, 0, 1'b0);
    chk("edge_wait_error", error_o, 0); chk("edge_wait_wv", weights_valid_o, 1);

    run_load(24'hFFFFF8, 1, 1'b1);
    chk("wrap_seen", saw_wrap, 1); chk("wrap_wv", weights_valid_o, 1);
    chk("wrap_writes", wr_count, 3);

    img = '{32'h4B570001, 32'd8};
    csum = 32'd8;
    for (int i = 0; i < 8; i++) begin
      img.push_back(32'(i * 3 + 1)); csum = csum + 32'(i * 3 + 1);
    end
    img.push_back(csum);
    begin_load(24'h000400, 1);
    n = 0;
    while (wr_count < 2 && n < 2000) begin @(posedge clk_i); #1; n++; end
    chk("midload_reached_data", (wr_count >= 2), 1);
    rst_ni = 1'b0;
    #1;
    chk("midrst_wr_en", wr_en_o, 0); chk("midrst_busy", busy_o, 0);
    chk("midrst_mem_valid", mem_valid_o, 0); chk("midrst_mem_addr", mem_addr_o, 0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    set_plan();
    run_load(24'h000100, 1, 1'b0);
    chk("reload_wv", weights_valid_o, 1); chk("reload_writes", wr_count, 3);

    for (int it = 0; it < 14; it++) begin
      build_rand();
      run_load(24'($urandom), int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk("rand_writes", wr_count, ana_writes > 0 && ana_code != 1 && ana_code != 2 ? wr_count : 0);
      chk("rand_code", err_code_o, (ana_code > 0) ? ana_code : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
